// File: rtl/rdma_xmit.sv
// rtl/rdma_xmit.sv - RDMA packet transmitter: one header beat followed by payload beats
module rdma_xmit #(
  parameter int          DATA_WBITS = 512,
  parameter int          MAX_BYTES  = 16384,
  parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP     = 32'h0A_01_01_01,
  parameter logic [31:0] DST_IP     = 32'h0A_01_01_02,
  parameter logic [15:0] SRC_PORT   = 16'd32002,
  parameter logic [15:0] DST_PORT   = 16'd32002,
  parameter logic [15:0] RDMA_MAGIC = 16'h0122
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [79:0]             CMD_TDATA,
  input  logic                    CMD_TVALID,
  output logic                    CMD_TREADY,
  input  logic [DATA_WBITS-1:0]   AXIS_SRC_TDATA,
  input  logic                    AXIS_SRC_TVALID,
  output logic                    AXIS_SRC_TREADY,
  output logic [DATA_WBITS-1:0]   AXIS_RDMA_TDATA,
  output logic [DATA_WBITS/8-1:0] AXIS_RDMA_TKEEP,
  output logic                    AXIS_RDMA_TVALID,
  output logic                    AXIS_RDMA_TLAST,
  input  logic                    AXIS_RDMA_TREADY,
  output logic [63:0]             packets_sent,
  output logic [31:0]             bad_cmds
);

  localparam int DATA_WBYTS = DATA_WBITS / 8;

  typedef enum logic [1:0] {IDLE, LOAD, HDR, DATA} state_t;

  state_t                 state, state_nxt;
  logic                   rdy_en;
  logic [63:0]            addr_q;
  logic [15:0]            len_q;
  logic [8:0]             beats_q;
  logic [DATA_WBYTS-1:0]  keep_q;
  logic [DATA_WBITS-1:0]  hdr_q;

  logic [15:0]            cmd_len;
  logic                   cmd_bad;
  logic                   cmd_fire;
  logic                   data_fire;
  logic                   data_last;

  logic [15:0]            udp_len;
  logic [15:0]            ip_len;
  logic [19:0]            csum_sum;
  logic [16:0]            csum_f1;
  logic [15:0]            csum_f2;
  logic [15:0]            csum;
  logic [DATA_WBITS-1:0]  hdr_be;
  logic [DATA_WBITS-1:0]  hdr_le;
  logic [16:0]            beats_rnd;
  logic [DATA_WBYTS-1:0]  keep_last;

  assign cmd_len   = CMD_TDATA[79:64];
  assign cmd_bad   = (cmd_len == 16'd0) || (int'(cmd_len) > MAX_BYTES);
  assign cmd_fire  = CMD_TVALID && CMD_TREADY;
  assign data_last = (beats_q == 9'd1);
  assign data_fire = (state == DATA) && AXIS_SRC_TVALID && AXIS_RDMA_TREADY;

  // Header fields and IPv4 checksum derived from the latched length/address
  always_comb begin
    udp_len   = len_q + 16'd30;
    ip_len    = udp_len + 16'd20;
    csum_sum  = 20'(16'h4500) + 20'(ip_len) + 20'(16'h4000) + 20'(16'h4011)
              + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
              + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    csum_f1   = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
    csum_f2   = csum_f1[15:0] + 16'(csum_f1[16]);
    csum      = ~csum_f2;
    hdr_be    = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, ip_len, 16'h0000, 16'h4000,
                 16'h4011, csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len,
                 16'h0000, RDMA_MAGIC, addr_q, 96'h0};
    hdr_le    = '0;
    for (int i = 0; i < DATA_WBYTS; i++) begin
      hdr_le[i*8 +: 8] = hdr_be[DATA_WBITS-1-i*8 -: 8];
    end
    beats_rnd = {1'b0, len_q} + 17'd63;
    keep_last = (len_q[5:0] == 6'd0) ? {DATA_WBYTS{1'b1}}
                                     : (DATA_WBYTS'(1) << len_q[5:0]) - DATA_WBYTS'(1);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Command latch, header/beat bookkeeping and statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en       <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      beats_q      <= '0;
      keep_q       <= '0;
      hdr_q        <= '0;
      packets_sent <= '0;
      bad_cmds     <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (cmd_fire) begin
        addr_q <= CMD_TDATA[63:0];
        len_q  <= cmd_len;
        if (cmd_bad) bad_cmds <= bad_cmds + 32'd1;
      end
      if (state == LOAD) begin
        hdr_q   <= hdr_le;
        beats_q <= beats_rnd[14:6];
        keep_q  <= keep_last;
      end
      if (data_fire) begin
        beats_q <= beats_q - 9'd1;
        if (data_last) packets_sent <= packets_sent + 64'd1;
      end
    end
  end

  // Next state and stream steering; payload is passed straight through in DATA
  always_comb begin
    state_nxt        = state;
    CMD_TREADY       = 1'b0;
    AXIS_SRC_TREADY  = 1'b0;
    AXIS_RDMA_TDATA  = '0;
    AXIS_RDMA_TKEEP  = '0;
    AXIS_RDMA_TVALID = 1'b0;
    AXIS_RDMA_TLAST  = 1'b0;
    case (state)
      IDLE: begin
        CMD_TREADY = rdy_en;
        if (CMD_TVALID && rdy_en && !cmd_bad) state_nxt = LOAD;
      end
      LOAD: state_nxt = HDR;
      HDR: begin
        AXIS_RDMA_TVALID = 1'b1;
        AXIS_RDMA_TKEEP  = {DATA_WBYTS{1'b1}};
        AXIS_RDMA_TDATA  = hdr_q;
        if (AXIS_RDMA_TREADY) state_nxt = DATA;
      end
      DATA: begin
        AXIS_RDMA_TVALID = AXIS_SRC_TVALID;
        AXIS_SRC_TREADY  = AXIS_RDMA_TREADY;
        AXIS_RDMA_TDATA  = AXIS_SRC_TDATA;
        AXIS_RDMA_TLAST  = data_last;
        AXIS_RDMA_TKEEP  = data_last ? keep_q : {DATA_WBYTS{1'b1}};
        if (data_fire && data_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rdma_xmit.sv
// tb/tb_rdma_xmit.sv - scoreboard bench for rdma_xmit
module tb_rdma_xmit;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [79:0]  CMD_TDATA = '0;
  logic         CMD_TVALID = 1'b0;
  logic         CMD_TREADY;
  logic [511:0] AXIS_SRC_TDATA = '0;
  logic         AXIS_SRC_TVALID = 1'b0;
  logic         AXIS_SRC_TREADY;
  logic [511:0] AXIS_RDMA_TDATA;
  logic [63:0]  AXIS_RDMA_TKEEP;
  logic         AXIS_RDMA_TVALID;
  logic         AXIS_RDMA_TLAST;
  logic         AXIS_RDMA_TREADY = 1'b0;
  logic [63:0]  packets_sent;
  logic [31:0]  bad_cmds;

  rdma_xmit dut (
    .clk(clk), .reset(reset),
    .CMD_TDATA(CMD_TDATA), .CMD_TVALID(CMD_TVALID), .CMD_TREADY(CMD_TREADY),
    .AXIS_SRC_TDATA(AXIS_SRC_TDATA), .AXIS_SRC_TVALID(AXIS_SRC_TVALID),
    .AXIS_SRC_TREADY(AXIS_SRC_TREADY),
    .AXIS_RDMA_TDATA(AXIS_RDMA_TDATA), .AXIS_RDMA_TKEEP(AXIS_RDMA_TKEEP),
    .AXIS_RDMA_TVALID(AXIS_RDMA_TVALID), .AXIS_RDMA_TLAST(AXIS_RDMA_TLAST),
    .AXIS_RDMA_TREADY(AXIS_RDMA_TREADY),
    .packets_sent(packets_sent), .bad_cmds(bad_cmds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         is_hdr;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic [63:0] addr;
  } cmd_t;

  beat_t        q[$];
  cmd_t         cq[$];
  int           checks = 0;
  int           errors = 0;
  int           src_idx = 0;
  int           exp_idx = 0;
  int           exp_pkts = 0;
  int           exp_bad = 0;
  int           data_hs = 0;
  bit           busy = 0;
  bit           throttle = 0;
  bit           stall_prev = 0;
  logic [511:0] stall_data;
  logic [511:0] last_hdr = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pay(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h9E37_79B9 + 32'h1357_2468;
    return {16{w}};
  endfunction

  function automatic logic [511:0] hdr_model(input logic [15:0] len, input logic [63:0] addr);
    logic [7:0]   b [64];
    logic [47:0]  dm, sm;
    logic [31:0]  sip, dip, s;
    logic [15:0]  ul, il, cs;
    logic [511:0] r;
    dm = 48'hFF_FF_FF_FF_FF_FF;
    sm = 48'h02_00_00_00_00_01;
    sip = 32'h0A_01_01_01;
    dip = 32'h0A_01_01_02;
    ul = len + 16'd30;
    il = ul + 16'd20;
    for (int k = 0; k < 64; k++) b[k] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      b[k]     = dm[47-8*k -: 8];
      b[6+k]   = sm[47-8*k -: 8];
    end
    b[12] = 8'h08; b[14] = 8'h45;
    b[16] = il[15:8]; b[17] = il[7:0];
    b[20] = 8'h40; b[22] = 8'h40; b[23] = 8'h11;
    for (int k = 0; k < 4; k++) begin
      b[26+k] = sip[31-8*k -: 8];
      b[30+k] = dip[31-8*k -: 8];
    end
    b[34] = 8'h7D; b[35] = 8'h02; b[36] = 8'h7D; b[37] = 8'h02;
    b[38] = ul[15:8]; b[39] = ul[7:0];
    b[42] = 8'h01; b[43] = 8'h22;
    for (int k = 0; k < 8; k++) b[44+k] = addr[63-8*k -: 8];
    s = 32'd0;
    for (int k = 0; k < 10; k++) s = s + 32'({b[14+2*k], b[15+2*k]});
    while ((s >> 16) != 32'd0) s = (s & 32'h0000_FFFF) + (s >> 16);
    cs = ~s[15:0];
    b[24] = cs[15:8]; b[25] = cs[7:0];
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = b[i];
    return r;
  endfunction

  function automatic bit len_bad(input logic [15:0] len);
    return (len == 16'd0) || (len > 16'd16384);
  endfunction

  task automatic push_pkt(input logic [15:0] len, input logic [63:0] addr);
    beat_t e;
    int    nb;
    cmd_t  c;
    c.len = len;
    c.addr = addr;
    cq.push_back(c);
    if (!len_bad(len)) begin
      e.data = hdr_model(len, addr); e.keep = '1; e.last = 1'b0; e.is_hdr = 1'b1;
      q.push_back(e);
      nb = (int'(len) + 63) / 64;
      for (int i = 0; i < nb; i++) begin
        e.data = pay(exp_idx);
        exp_idx++;
        e.last = (i == nb - 1);
        e.is_hdr = 1'b0;
        if (e.last && (int'(len) % 64 != 0)) e.keep = (64'h1 << (int'(len) % 64)) - 64'h1;
        else e.keep = '1;
        q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    if (busy) chk("cmd_tready_busy", 512'(CMD_TREADY), 512'(0));
    if (CMD_TVALID && CMD_TREADY) begin
      if (len_bad(cq[0].len)) exp_bad++;
      else busy = 1;
      void'(cq.pop_front());
    end
    if (AXIS_SRC_TVALID && AXIS_SRC_TREADY) src_idx++;
    if (stall_prev) begin
      chk("hdr_hold_valid", 512'(AXIS_RDMA_TVALID), 512'(1));
      chk("hdr_hold_data", AXIS_RDMA_TDATA, stall_data);
    end
    stall_prev = 0;
    if (AXIS_RDMA_TVALID) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 512'(AXIS_RDMA_TVALID), 512'(0));
      end else if (AXIS_RDMA_TREADY) begin
        e = q.pop_front();
        chk(e.is_hdr ? "hdr_data" : "beat_data", AXIS_RDMA_TDATA, e.data);
        chk("beat_keep", 512'(AXIS_RDMA_TKEEP), 512'(e.keep));
        chk("beat_last", 512'(AXIS_RDMA_TLAST), 512'(e.last));
        if (e.is_hdr) last_hdr = AXIS_RDMA_TDATA;
        else data_hs++;
        if (e.last) begin
          busy = 0;
          exp_pkts++;
        end
      end else if (q[0].is_hdr) begin
        stall_prev = 1;
        stall_data = AXIS_RDMA_TDATA;
      end
    end
  endtask

  task automatic run(input int budget, input int stop_data);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done) begin
      @(posedge clk); #1;
      CMD_TVALID = (cq.size() > 0);
      if (cq.size() > 0) CMD_TDATA = {cq[0].len, cq[0].addr};
      AXIS_SRC_TVALID  = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
      AXIS_SRC_TDATA   = pay(src_idx);
      AXIS_RDMA_TREADY = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      monitor();
      n++;
      if (stop_data > 0 && data_hs >= stop_data) done = 1;
      else if (q.size() == 0 && cq.size() == 0) done = 1;
      else if (n >= budget) begin
        chk("pending_at_timeout", 512'(q.size() + cq.size()), 512'(0));
        done = 1;
      end
    end
    if (stop_data == 0) begin
      @(posedge clk); #1;
      CMD_TVALID = 1'b0;
      AXIS_SRC_TVALID = 1'b0;
      AXIS_RDMA_TREADY = 1'b1;
    end
  endtask

  initial begin
    #2;
    chk("rst_cmd_tready", 512'(CMD_TREADY), 512'(0));
    chk("rst_tvalid", 512'(AXIS_RDMA_TVALID), 512'(0));
    chk("rst_tlast", 512'(AXIS_RDMA_TLAST), 512'(0));
    chk("rst_tkeep", 512'(AXIS_RDMA_TKEEP), 512'(0));
    chk("rst_tdata", AXIS_RDMA_TDATA, 512'(0));
    chk("rst_pkts", 512'(packets_sent), 512'(0));
    chk("rst_bad", 512'(bad_cmds), 512'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cmd_tready_after_rst", 512'(CMD_TREADY), 512'(1));

    push_pkt(16'd64, 64'h1000_0000_0000_0040);
    run(200, 0);
    chk("pkts_len64", 512'(packets_sent), 512'(exp_pkts));
    chk("udp_length", 512'({last_hdr[38*8 +: 8], last_hdr[39*8 +: 8]}), 512'(16'h005E));
    chk("ip4_length", 512'({last_hdr[16*8 +: 8], last_hdr[17*8 +: 8]}), 512'(16'h0072));

    push_pkt(16'd130, 64'h0000_0000_DEAD_BEEF);
    run(200, 0);
    chk("pkts_len130", 512'(packets_sent), 512'(exp_pkts));

    push_pkt(16'd0, 64'h1);
    push_pkt(16'd16385, 64'h2);
    run(50, 0);
    chk("bad_cmds", 512'(bad_cmds), 512'(exp_bad));
    chk("cmd_tready_after_bad", 512'(CMD_TREADY), 512'(1));
    chk("pkts_after_bad", 512'(packets_sent), 512'(exp_pkts));

    throttle = 1;
    push_pkt(16'd16384, 64'h0123_4567_89AB_CDEF);
    run(6000, 0);
    throttle = 0;
    chk("pkts_len16384", 512'(packets_sent), 512'(exp_pkts));

    data_hs = 0;
    push_pkt(16'd640, 64'h0000_0000_0000_1000);
    run(200, 4);
    @(posedge clk); #1;
    chk("fifth_beat_valid", 512'(AXIS_RDMA_TVALID), 512'(1));
    reset = 1'b1;
    #1;
    chk("reset_drops_tvalid", 512'(AXIS_RDMA_TVALID), 512'(0));
    chk("reset_drops_cmd_tready", 512'(CMD_TREADY), 512'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    cq.delete();
    src_idx = exp_idx;
    busy = 0;
    stall_prev = 0;
    exp_pkts = 0;
    exp_bad = 0;
    CMD_TVALID = 1'b0;
    AXIS_SRC_TVALID = 1'b0;
    chk("pkts_cleared", 512'(packets_sent), 512'(0));
    chk("bad_cleared", 512'(bad_cmds), 512'(0));

    push_pkt(16'd200, 64'h0000_0000_0000_2000);
    run(200, 0);
    chk("pkts_after_reset", 512'(packets_sent), 512'(exp_pkts));

    push_pkt(16'd100, 64'h0000_0000_0000_3000);
    push_pkt(16'd64, 64'h0000_0000_0000_4000);
    run(300, 0);
    chk("pkts_back_to_back", 512'(packets_sent), 512'(exp_pkts));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
